// File: rtl/tstamp_pkg.sv
// Shared constants and helpers for the timestamp capture block.
// Defaults are sized for a 1000:1 prescaled 32-bit time base.
package tstamp_pkg;

  localparam int R_MAIN_TO_LOW = 1000;
  localparam int TW            = 32;
  localparam int DEPTH         = 8;
  localparam int DW            = 16;

  typedef logic [TW-1:0] tstamp_t;

  // Occupancy needs one extra bit so that a full FIFO (level == depth) is representable.
  function automatic int level_width(input int d);
    return $clog2(d) + 1;
  endfunction

endpackage

// File: rtl/tstamp_fifo.sv
// First-word-fall-through FIFO with a registered head and an occupancy counter.
// A push into a full FIFO is accepted only when a pop frees the head slot in the same cycle.
module tstamp_fifo
  import tstamp_pkg::*;
#(
  parameter int depth = DEPTH,
  parameter int width = TW
) (
  input  logic                          clk_main,
  input  logic                          clr_n,
  input  logic                          push,
  input  logic [width-1:0]              push_data,
  input  logic                          pop,
  output logic [width-1:0]              head_data,
  output logic                          head_valid,
  output logic                          full,
  output logic [level_width(depth)-1:0] level
);

  localparam int AW = $clog2(depth);
  localparam int LW = level_width(depth);

  logic [width-1:0] r_mem [depth];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic [width-1:0] r_head;
  logic             r_valid;

  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic [AW-1:0]    w_rd_inc;
  logic [LW-1:0]    w_level_next;
  logic [width-1:0] w_head_next;
  logic             w_valid_next;

  assign w_full   = (r_level == LW'(depth));
  assign w_pop    = pop & r_valid;
  assign w_push   = push & (~w_full | w_pop);
  assign w_rd_inc = r_rd_ptr + AW'(1);

  // occupancy update from the accepted push/pop pair
  always_comb begin
    w_level_next = r_level;
    case ({w_push, w_pop})
      2'b10:   w_level_next = r_level + LW'(1);
      2'b01:   w_level_next = r_level - LW'(1);
      default: w_level_next = r_level;
    endcase
  end

  // next head: the slot behind the popped one, or the incoming word when it lands on an empty head
  always_comb begin
    w_head_next  = r_head;
    w_valid_next = r_valid;
    if (w_pop) begin
      if (r_level > LW'(1)) begin
        w_head_next = r_mem[w_rd_inc];
      end else if (w_push) begin
        w_head_next = push_data;
      end else begin
        w_valid_next = 1'b0;
      end
    end else if (!r_valid && w_push) begin
      w_head_next  = push_data;
      w_valid_next = 1'b1;
    end else begin
      w_head_next = r_head;
    end
  end

  // storage, pointers, occupancy and registered head
  always_ff @(posedge clk_main or negedge clr_n) begin
    if (!clr_n) begin
      for (int i = 0; i < depth; i++) begin
        r_mem[i] <= {width{1'b0}};
      end
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_level  <= {LW{1'b0}};
      r_head   <= {width{1'b0}};
      r_valid  <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= push_data;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= w_rd_inc;
      end
      r_level <= w_level_next;
      r_head  <= w_head_next;
      r_valid <= w_valid_next;
    end
  end

  assign head_data  = r_head;
  assign head_valid = r_valid;
  assign full       = w_full;
  assign level      = r_level;

endmodule

// File: rtl/tstamp_capture.sv
// Latches a prescaled free-running time on each rising edge of the extended pulse
// and queues it for readout, counting events lost to a full queue.
module tstamp_capture
  import tstamp_pkg::*;
#(
  parameter int r_main_to_low = R_MAIN_TO_LOW,
  parameter int tw            = TW,
  parameter int depth         = DEPTH,
  parameter int dw            = DW
) (
  input  logic                          clk_main,
  input  logic                          clr_n,
  input  logic                          tstamp_in,
  input  logic                          clear_ovf,
  output logic [tw-1:0]                 ts_data,
  output logic                          ts_valid,
  input  logic                          ts_ready,
  output logic [level_width(depth)-1:0] fifo_level,
  output logic                          ovf,
  output logic [dw-1:0]                 drop_cnt,
  output logic [tw-1:0]                 time_now
);

  localparam int PW = (r_main_to_low > 1) ? $clog2(r_main_to_low) : 1;

  logic [PW-1:0] r_pre_cnt;
  logic [tw-1:0] r_time;
  logic          r_tin_d;
  logic          r_ovf;
  logic [dw-1:0] r_drop_cnt;

  logic          w_tick;
  logic          w_edge;
  logic          w_full;
  logic          w_valid;
  logic          w_pop;
  logic          w_drop;
  logic          w_drop_sat;

  // with a ratio of 1 the counter stays at zero and ticks every cycle
  assign w_tick     = (r_pre_cnt == PW'(r_main_to_low - 1));
  assign w_edge     = tstamp_in & ~r_tin_d;
  assign w_pop      = w_valid & ts_ready;
  assign w_drop     = w_edge & w_full & ~w_pop;
  assign w_drop_sat = &r_drop_cnt;

  // prescaler, time base and edge-detect delay
  always_ff @(posedge clk_main or negedge clr_n) begin
    if (!clr_n) begin
      r_pre_cnt <= {PW{1'b0}};
      r_time    <= {tw{1'b0}};
      r_tin_d   <= 1'b0;
    end else begin
      if (w_tick) begin
        r_pre_cnt <= {PW{1'b0}};
        r_time    <= r_time + tw'(1);
      end else begin
        r_pre_cnt <= r_pre_cnt + PW'(1);
      end
      r_tin_d <= tstamp_in;
    end
  end

  // overflow flag and drop counter; a drop in the clearing cycle restarts the count at one
  always_ff @(posedge clk_main or negedge clr_n) begin
    if (!clr_n) begin
      r_ovf      <= 1'b0;
      r_drop_cnt <= {dw{1'b0}};
    end else if (w_drop) begin
      r_ovf <= 1'b1;
      if (clear_ovf) begin
        r_drop_cnt <= dw'(1);
      end else if (!w_drop_sat) begin
        r_drop_cnt <= r_drop_cnt + dw'(1);
      end
    end else if (clear_ovf) begin
      r_ovf      <= 1'b0;
      r_drop_cnt <= {dw{1'b0}};
    end
  end

  tstamp_fifo #(
    .depth (depth),
    .width (tw)
  ) u_fifo (
    .clk_main   (clk_main),
    .clr_n      (clr_n),
    .push       (w_edge),
    .push_data  (r_time),
    .pop        (ts_ready),
    .head_data  (ts_data),
    .head_valid (w_valid),
    .full       (w_full),
    .level      (fifo_level)
  );

  assign ts_valid = w_valid;
  assign ovf      = r_ovf;
  assign drop_cnt = r_drop_cnt;
  assign time_now = r_time;

endmodule

// File: tb/tb_tstamp_capture.sv
// Directed scoreboard bench: instance A (ratio 4, depth 4) and instance B (ratio 1, 4-bit time, 2-bit drops).
module tb_tstamp_capture;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        clr_a, tin_a, clr_ovf_a, rdy_a;
  logic [31:0] data_a, time_a;
  logic        valid_a, ovf_a;
  logic [2:0]  lvl_a;
  logic [15:0] drop_a;

  logic        clr_b, tin_b, clr_ovf_b, rdy_b;
  logic [3:0]  data_b, time_b;
  logic        valid_b, ovf_b;
  logic [2:0]  lvl_b;
  logic [1:0]  drop_b;

  int          n_cmp = 0;
  int          n_mis = 0;
  int          cyc_a;
  int          cyc_b;
  logic [31:0] qa[$];
  logic [31:0] qb[$];

  tstamp_capture #(.r_main_to_low(4), .tw(32), .depth(4), .dw(16)) u_dut_a (
    .clk_main(clk), .clr_n(clr_a), .tstamp_in(tin_a), .clear_ovf(clr_ovf_a),
    .ts_data(data_a), .ts_valid(valid_a), .ts_ready(rdy_a), .fifo_level(lvl_a),
    .ovf(ovf_a), .drop_cnt(drop_a), .time_now(time_a)
  );

  tstamp_capture #(.r_main_to_low(1), .tw(4), .depth(4), .dw(2)) u_dut_b (
    .clk_main(clk), .clr_n(clr_b), .tstamp_in(tin_b), .clear_ovf(clr_ovf_b),
    .ts_data(data_b), .ts_valid(valid_b), .ts_ready(rdy_b), .fifo_level(lvl_b),
    .ovf(ovf_b), .drop_cnt(drop_b), .time_now(time_b)
  );

  // reference time base: clock edges seen since reset release
  always @(posedge clk or negedge clr_a) begin
    if (!clr_a) cyc_a <= 0;
    else        cyc_a <= cyc_a + 1;
  end

  always @(posedge clk or negedge clr_b) begin
    if (!clr_b) cyc_b <= 0;
    else        cyc_b <= cyc_b + 1;
  end

  function automatic logic [31:0] mt(input bit sel);
    if (sel) return 32'(cyc_b % 16);
    return 32'(cyc_a / 4);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rst(input bit sel);
    if (sel) begin clr_b = 1'b0; qb.delete(); end
    else     begin clr_a = 1'b0; qa.delete(); end
    repeat (2) @(negedge clk);
    if (sel) clr_b = 1'b1;
    else     clr_a = 1'b1;
  endtask

  task automatic pulse(input bit sel, input int len, input bit keep);
    if (sel) begin tin_b = 1'b1; if (keep) qb.push_back(mt(1'b1)); end
    else     begin tin_a = 1'b1; if (keep) qa.push_back(mt(1'b0)); end
    repeat (len) @(negedge clk);
    if (sel) tin_b = 1'b0;
    else     tin_a = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_time(input bit sel, input logic [31:0] t);
    for (int i = 0; i < 400 && mt(sel) != t; i++) @(negedge clk);
    chk(sel ? "time_b" : "time_a", sel ? 32'(time_b) : time_a, t);
  endtask

  task automatic drain(input bit sel, input int n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] e;
      e = 32'hDEAD_BEEF;
      if (sel) begin
        if (qb.size() > 0) e = qb.pop_front();
        chk("drain_valid_b", 32'(valid_b), 32'd1);
        chk("drain_data_b", 32'(data_b), e);
        rdy_b = 1'b1;
      end else begin
        if (qa.size() > 0) e = qa.pop_front();
        chk("drain_valid_a", 32'(valid_a), 32'd1);
        chk("drain_data_a", data_a, e);
        rdy_a = 1'b1;
      end
      @(negedge clk);
    end
    rdy_a = 1'b0;
    rdy_b = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] e;
    clr_a = 1'b0; tin_a = 1'b0; clr_ovf_a = 1'b0; rdy_a = 1'b0;
    clr_b = 1'b0; tin_b = 1'b0; clr_ovf_b = 1'b0; rdy_b = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(valid_a), 32'd0);
    chk("rst_data", data_a, 32'd0);
    chk("rst_level", 32'(lvl_a), 32'd0);
    chk("rst_ovf", 32'(ovf_a), 32'd0);
    chk("rst_drop", 32'(drop_a), 32'd0);
    chk("rst_time", time_a, 32'd0);
    chk("rst_time_b", 32'(time_b), 32'd0);
    clr_a = 1'b1;
    clr_b = 1'b1;

    // single capture from a 10-cycle pulse
    wait_time(1'b0, 32'd5);
    tin_a = 1'b1;
    qa.push_back(mt(1'b0));
    @(negedge clk);
    chk("single_valid", 32'(valid_a), 32'd1);
    chk("single_data", data_a, 32'd5);
    repeat (9) @(negedge clk);
    tin_a = 1'b0;
    @(negedge clk);
    chk("single_level", 32'(lvl_a), 32'd1);
    drain(1'b0, 1);
    chk("single_empty", 32'(valid_a), 32'd0);
    rdy_a = 1'b1;
    repeat (2) @(negedge clk);
    rdy_a = 1'b0;
    chk("ready_when_empty", 32'(lvl_a), 32'd0);

    // handshake hold
    rst(1'b0);
    wait_time(1'b0, 32'd2);  pulse(1'b0, 2, 1'b1);
    wait_time(1'b0, 32'd7);  pulse(1'b0, 2, 1'b1);
    wait_time(1'b0, 32'd12); pulse(1'b0, 2, 1'b1);
    chk("hold_level", 32'(lvl_a), 32'd3);
    chk("hold_head", data_a, 32'd2);
    drain(1'b0, 3);
    chk("hold_level_end", 32'(lvl_a), 32'd0);
    chk("hold_valid_end", 32'(valid_a), 32'd0);

    // overflow
    rst(1'b0);
    for (int i = 0; i < 6; i++) pulse(1'b0, 1, i < 4);
    chk("ovf_level", 32'(lvl_a), 32'd4);
    chk("ovf_flag", 32'(ovf_a), 32'd1);
    chk("ovf_drop", 32'(drop_a), 32'd2);
    chk("ovf_head", data_a, qa[0]);
    clr_ovf_a = 1'b1;
    @(negedge clk);
    clr_ovf_a = 1'b0;
    chk("clr_ovf", 32'(ovf_a), 32'd0);
    chk("clr_drop", 32'(drop_a), 32'd0);
    chk("clr_level", 32'(lvl_a), 32'd4);

    // full with simultaneous pop and push
    e = qa.pop_front();
    chk("sim_head", data_a, e);
    tin_a = 1'b1;
    rdy_a = 1'b1;
    qa.push_back(mt(1'b0));
    @(negedge clk);
    tin_a = 1'b0;
    rdy_a = 1'b0;
    chk("sim_level", 32'(lvl_a), 32'd4);
    chk("sim_drop", 32'(drop_a), 32'd0);
    chk("sim_ovf", 32'(ovf_a), 32'd0);
    @(negedge clk);

    // drop coinciding with clear_ovf
    tin_a = 1'b1;
    clr_ovf_a = 1'b1;
    @(negedge clk);
    tin_a = 1'b0;
    clr_ovf_a = 1'b0;
    chk("dropwin_ovf", 32'(ovf_a), 32'd1);
    chk("dropwin_drop", 32'(drop_a), 32'd1);
    chk("dropwin_level", 32'(lvl_a), 32'd4);
    @(negedge clk);
    drain(1'b0, 4);

    // asynchronous reset with three entries queued and ovf set
    for (int i = 0; i < 3; i++) pulse(1'b0, 1, 1'b1);
    chk("pre_rst_level", 32'(lvl_a), 32'd3);
    chk("pre_rst_ovf", 32'(ovf_a), 32'd1);
    #2;
    clr_a = 1'b0;
    #1;
    chk("async_valid", 32'(valid_a), 32'd0);
    chk("async_level", 32'(lvl_a), 32'd0);
    chk("async_ovf", 32'(ovf_a), 32'd0);
    chk("async_time", time_a, 32'd0);
    chk("async_drop", 32'(drop_a), 32'd0);
    qa.delete();
    @(negedge clk);
    clr_a = 1'b1;

    // wrap with tick every cycle, drop counter saturation
    rst(1'b1);
    wait_time(1'b1, 32'd15);
    tin_b = 1'b1;
    qb.push_back(mt(1'b1));
    @(negedge clk);
    chk("wrap_data", 32'(data_b), 32'd15);
    chk("wrap_time", 32'(time_b), 32'd0);
    tin_b = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) pulse(1'b1, 1, 1'b1);
    for (int i = 0; i < 3; i++) pulse(1'b1, 1, 1'b0);
    chk("sat_drop3", 32'(drop_b), 32'd3);
    for (int i = 0; i < 2; i++) pulse(1'b1, 1, 1'b0);
    chk("sat_drop5", 32'(drop_b), 32'd3);
    chk("sat_ovf", 32'(ovf_b), 32'd1);
    chk("sat_level", 32'(lvl_b), 32'd4);
    drain(1'b1, 4);
    chk("sat_empty", 32'(valid_b), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
